ins_fetch_queue: RTL

//  Instruction fetch front end sitting between the instruction RAM and the cpu core.
//  - Owns the fetch PC and issues sequential word reads to a 1-cycle synchronous instruction RAM.
//  - Buffers returned words with their PC in a DEPTH-entry prefetch queue.
//  - Presents them to the core over a valid/ready handshake.
//  - On a taken branch (CBZ/B), the core redirects the PC; the queue flushes and refetches.

---
 rtl/ins_fetch_pkg.sv | 12 +
 rtl/ins_fetch_queue_if.sv | 29 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/ins_fetch_queue.sv | 86 ++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// Shared widths and the prefetch queue entry type for the instruction fetch front end.
package ins_fetch_pkg;

  localparam int ADDR_W = 5;
  localparam int INS_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
  } fq_entry_t;

endpackage

// File: rtl/ins_fetch_queue_if.sv
// Bundles the instruction RAM read port, the core redirect port and the head handshake.
interface ins_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ins_fetch_pkg::ADDR_W,
  parameter int INS_W  = ins_fetch_pkg::INS_W
);

  logic                         imem_rd_en;
  logic [ADDR_W-1:0]            imem_addr;
  logic [INS_W-1:0]             imem_rdata;
  logic                         redirect_valid;
  logic [ADDR_W-1:0]            redirect_pc;
  logic                         ins_valid;
  logic                         ins_ready;
  logic [INS_W-1:0]             ins_reg;
  logic [ADDR_W-1:0]            ins_pc;
  logic [$clog2(DEPTH+1)-1:0]   fq_count;

  modport master (
    output imem_rd_en, imem_addr, ins_valid, ins_reg, ins_pc, fq_count,
    input  imem_rdata, redirect_valid, redirect_pc, ins_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, ins_valid, ins_reg, ins_pc, fq_count,
    output imem_rdata, redirect_valid, redirect_pc, ins_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instruction}; pointers carry an extra wrap bit
// so the occupancy count alone distinguishes full from empty.
module fetch_fifo
  import ins_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fq_entry_t                  din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fq_entry_t                  head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t   mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign count = CW'(wr_ptr - rd_ptr);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Issue throttling guarantees a slot for every outstanding response.
  no_overflow: assert property (@(posedge clk) disable iff (!reset || flush)
                                !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, prefetches into a small queue, flushes on redirect.
// Optional FETCH_BYPASS_EN forwards RAM data straight to the core when the queue is empty.
module ins_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ins_fetch_pkg::ADDR_W,
  parameter int INS_W  = ins_fetch_pkg::INS_W
) (
  input logic               clk,
  input logic               reset,
  ins_fetch_queue_if.master bus
);

  import ins_fetch_pkg::fq_entry_t;

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              resp_pending;
  logic              issue;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic              bypass_take;
  logic [CW-1:0]     count;
  fq_entry_t         head;
  fq_entry_t         push_entry;
  fq_entry_t         out_entry;

  // Room is judged before this cycle's pop, so a full queue waits one extra cycle.
  assign issue = reset & ~bus.redirect_valid &
                 (({1'b0, count} + (CW+1)'(resp_pending)) < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc     <= '0;
      req_pc       <= '0;
      resp_pending <= 1'b0;
    end else begin
      resp_pending <= issue;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_pc   <= fetch_pc;
      end
    end
  end

  assign push_entry = '{pc: req_pc, ins: bus.imem_rdata};
  assign head_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
  logic bypass_active;
  assign bypass_active = ~head_valid & resp_pending & ~bus.redirect_valid;
  assign bypass_take   = bypass_active & bus.ins_ready;
  assign out_entry     = head_valid ? head : push_entry;
  assign bus.ins_valid = head_valid | bypass_active;
`else
  assign bypass_take   = 1'b0;
  assign out_entry     = head;
  assign bus.ins_valid = head_valid;
`endif

  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push = resp_pending & ~bus.redirect_valid & ~bypass_take;
  assign pop  = head_valid & bus.ins_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.ins_reg    = bus.ins_valid ? out_entry.ins : '0;
  assign bus.ins_pc     = bus.ins_valid ? out_entry.pc  : '0;
  assign bus.fq_count   = count;

endmodule
